// File: rtl/board_ctrl.sv
// board_ctrl: board-level support for ice40 SoC tops.
// Holds the SoC in reset after power-up, after rst and after a long press of
// button 0; debounces the board buttons; shows a page of the SoC trace bus on
// the LEDs, with button 1 stepping pages and button 2 freezing the display.
module board_ctrl #(
    parameter int POR_CYCLES      = 8388607,
    parameter int BUTTONS         = 3,
    parameter int BTN_ACTIVE_LOW  = 0,
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int HOLD_CYCLES     = 24000000,
    parameter int TRACE_W         = 12,
    parameter int LED_W           = 12,
    parameter int LED_ACTIVE_LOW  = 1,
    localparam int PAGES          = (TRACE_W + LED_W - 1) / LED_W,
    localparam int PG_W           = (PAGES > 1) ? $clog2(PAGES) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [BUTTONS-1:0] btn_raw,
    input  logic [TRACE_W-1:0] trace,
    output logic               soc_rst,
    output logic [BUTTONS-1:0] btn_level,
    output logic [BUTTONS-1:0] btn_press,
    output logic [PG_W-1:0]    page,
    output logic               frozen,
    output logic [LED_W-1:0]   led
);

    localparam int POR_W  = $clog2(POR_CYCLES + 1);
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int EXT_W  = PAGES * LED_W;

    // Raw pin level of an unpressed button, and LED drive level for "off".
    localparam logic [BUTTONS-1:0] BTN_INV = (BTN_ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [LED_W-1:0]   LED_INV = (LED_ACTIVE_LOW != 0) ? '1 : '0;

    generate
        if (BUTTONS < 3) begin : g_bad_buttons
            $error("board_ctrl: BUTTONS must be at least 3");
        end
        if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
            $error("board_ctrl: DEBOUNCE_CYCLES must be at least 2");
        end
        if (POR_CYCLES < 1) begin : g_bad_por
            $error("board_ctrl: POR_CYCLES must be at least 1");
        end
    endgenerate

    logic [BUTTONS-1:0] sync1_r;
    logic [BUTTONS-1:0] sync2_r;
    logic [BUTTONS-1:0] btn_norm_s;
    logic [DB_W-1:0]    db_cnt_r [BUTTONS];
    logic [DB_W-1:0]    db_cnt_s [BUTTONS];
    logic [BUTTONS-1:0] level_r;
    logic [BUTTONS-1:0] level_s;
    logic [BUTTONS-1:0] level_d_r;
    logic [BUTTONS-1:0] press_r;
    logic [HOLD_W-1:0]  hold_cnt_r;
    logic               soft_req_r;
    logic [POR_W-1:0]   por_cnt_r;
    logic [POR_W-1:0]   por_cnt_s;
    logic               soc_rst_r;
    logic [PG_W-1:0]    page_r;
    logic               frozen_r;
    logic [TRACE_W-1:0] snap_r;
    logic [EXT_W-1:0]   ext_s;
    logic [LED_W-1:0]   view_s;
    logic [LED_W-1:0]   led_r;

    // Two-flop synchroniser; resets to the idle pin level so nothing looks pressed.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= BTN_INV;
            sync2_r <= BTN_INV;
        end else begin
            sync1_r <= btn_raw;
            sync2_r <= sync1_r;
        end
    end

    assign btn_norm_s = sync2_r ^ BTN_INV;

    // Debounce next state: the stable level flips after DEBOUNCE_CYCLES differing samples.
    always_comb begin
        level_s  = level_r;
        db_cnt_s = '{default: '0};
        for (int i = 0; i < BUTTONS; i++) begin
            if (btn_norm_s[i] != level_r[i]) begin
                if (db_cnt_r[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    level_s[i]  = ~level_r[i];
                    db_cnt_s[i] = '0;
                end else begin
                    db_cnt_s[i] = db_cnt_r[i] + DB_W'(1);
                end
            end else begin
                db_cnt_s[i] = '0;
            end
        end
    end

    // Debounce state and press-edge pulse (one cycle, the cycle after the level rises).
    always_ff @(posedge clk) begin
        if (rst) begin
            db_cnt_r  <= '{default: '0};
            level_r   <= '0;
            level_d_r <= '0;
            press_r   <= '0;
        end else begin
            db_cnt_r  <= db_cnt_s;
            level_r   <= level_s;
            level_d_r <= level_r;
            press_r   <= level_r & ~level_d_r;
        end
    end

    // Long-press detector on button 0: one request per hold, re-armed by release.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt_r <= '0;
            soft_req_r <= 1'b0;
        end else begin
            if (!level_r[0]) begin
                hold_cnt_r <= '0;
            end else if (hold_cnt_r < HOLD_W'(HOLD_CYCLES)) begin
                hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
            end else begin
                hold_cnt_r <= hold_cnt_r;
            end
            soft_req_r <= level_r[0] && (hold_cnt_r == HOLD_W'(HOLD_CYCLES - 1));
        end
    end

    // POR counter next value: restart on a soft-reset request, else count up and saturate.
    always_comb begin
        por_cnt_s = por_cnt_r;
        if (soft_req_r) begin
            por_cnt_s = '0;
        end else if (por_cnt_r < POR_W'(POR_CYCLES)) begin
            por_cnt_s = por_cnt_r + POR_W'(1);
        end else begin
            por_cnt_s = por_cnt_r;
        end
    end

    // POR counter and registered SoC reset, high while the count is below POR_CYCLES.
    always_ff @(posedge clk) begin
        if (rst) begin
            por_cnt_r <= '0;
            soc_rst_r <= 1'b1;
        end else begin
            por_cnt_r <= por_cnt_s;
            soc_rst_r <= (por_cnt_s < POR_W'(POR_CYCLES));
        end
    end

    // Page stepping and freeze toggle; the snapshot is taken as the display freezes.
    always_ff @(posedge clk) begin
        if (rst) begin
            page_r   <= '0;
            frozen_r <= 1'b0;
            snap_r   <= '0;
        end else begin
            if (press_r[1]) begin
                page_r <= (page_r == PG_W'(PAGES - 1)) ? '0 : page_r + PG_W'(1);
            end else begin
                page_r <= page_r;
            end
            if (press_r[2]) begin
                frozen_r <= ~frozen_r;
                snap_r   <= frozen_r ? snap_r : trace;
            end else begin
                frozen_r <= frozen_r;
                snap_r   <= snap_r;
            end
        end
    end

    // Select the displayed page from the zero-padded live or frozen trace.
    always_comb begin
        ext_s              = '0;
        ext_s[TRACE_W-1:0] = frozen_r ? snap_r : trace;
        view_s             = '0;
        for (int p = 0; p < PAGES; p++) begin
            view_s = (page_r == PG_W'(p)) ? ext_s[p*LED_W +: LED_W] : view_s;
        end
    end

    // Registered LED drive with board polarity applied.
    always_ff @(posedge clk) begin
        if (rst) begin
            led_r <= LED_INV;
        end else begin
            led_r <= view_s ^ LED_INV;
        end
    end

    assign soc_rst   = soc_rst_r;
    assign btn_level = level_r;
    assign btn_press = press_r;
    assign page      = page_r;
    assign frozen    = frozen_r;
    assign led       = led_r;

endmodule

// File: tb/tb_board_ctrl.sv
// Self-checking bench for board_ctrl: directed scenarios followed by random
// button/trace/reset activity, all compared against a cycle model kept here.
module tb_board_ctrl;

    localparam int POR   = 16;
    localparam int DB    = 4;
    localparam int HOLD  = 32;
    localparam int TW    = 12;
    localparam int LW    = 8;
    localparam int NB    = 3;
    localparam int PAGES = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [NB-1:0] btn_raw;
    logic [TW-1:0] trace;
    logic          soc_rst;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_press;
    logic [0:0]    page;
    logic          frozen;
    logic [LW-1:0] led;

    board_ctrl #(
        .POR_CYCLES(POR), .BUTTONS(NB), .BTN_ACTIVE_LOW(0), .DEBOUNCE_CYCLES(DB),
        .HOLD_CYCLES(HOLD), .TRACE_W(TW), .LED_W(LW), .LED_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst(rst), .btn_raw(btn_raw), .trace(trace),
        .soc_rst(soc_rst), .btn_level(btn_level), .btn_press(btn_press),
        .page(page), .frozen(frozen), .led(led)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state (values visible after each clock edge).
    int            m_age;
    bit            m_soc;
    logic [NB-1:0] m_d1, m_d2;
    logic [NB-1:0] m_lvl, m_rose, m_press;
    int            m_run [NB];
    int            m_hold;
    bit            m_req;
    int            m_page;
    bit            m_frozen;
    logic [TW-1:0] m_snap;
    logic [LW-1:0] m_led;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs present before the edge.
    task automatic model_edge();
        logic [2*LW-1:0] full;
        bit flip;
        if (rst) begin
            m_age = 0; m_soc = 1'b1;
            m_d1 = '0; m_d2 = '0; m_lvl = '0; m_rose = '0; m_press = '0;
            for (int i = 0; i < NB; i++) m_run[i] = 0;
            m_hold = 0; m_req = 1'b0;
            m_page = 0; m_frozen = 1'b0; m_snap = '0;
            m_led = 8'hFF;
        end else begin
            full  = (2*LW)'(m_frozen ? m_snap : trace);
            m_led = ~LW'(full >> (m_page * LW));
            if (m_press[1]) m_page = (m_page + 1) % PAGES;
            if (m_press[2]) begin
                if (!m_frozen) m_snap = trace;
                m_frozen = !m_frozen;
            end
            m_age = m_req ? 0 : ((m_age < POR) ? m_age + 1 : POR);
            m_soc = (m_age < POR);
            if (m_lvl[0]) begin
                m_req  = (m_hold == HOLD - 1);
                m_hold = (m_hold < HOLD) ? m_hold + 1 : HOLD;
            end else begin
                m_req  = 1'b0;
                m_hold = 0;
            end
            m_press = m_rose;
            for (int i = 0; i < NB; i++) begin
                flip = 1'b0;
                m_run[i] = (m_d2[i] != m_lvl[i]) ? m_run[i] + 1 : 0;
                if (m_run[i] == DB) begin
                    flip = 1'b1;
                    m_run[i] = 0;
                    m_lvl[i] = ~m_lvl[i];
                end
                m_rose[i] = flip && m_lvl[i];
            end
            m_d2 = m_d1;
            m_d1 = btn_raw;
        end
    endtask

    // One clock: update the model at the edge, then compare every output shortly after.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_eq("soc_rst",   32'(soc_rst),   32'(m_soc));
        check_eq("btn_level", 32'(btn_level), 32'(m_lvl));
        check_eq("btn_press", 32'(btn_press), 32'(m_press));
        check_eq("page",      32'(page),      32'(m_page));
        check_eq("frozen",    32'(frozen),    32'(m_frozen));
        check_eq("led",       32'(led),       32'(m_led));
    endtask

    task automatic press_button(input int b);
        btn_raw[b] = 1'b1;
        repeat (8) tick();
        btn_raw[b] = 1'b0;
        repeat (8) tick();
    endtask

    initial begin
        int highs, rises, presses, rise_at;
        bit prev;
        rst = 1'b1; btn_raw = '0; trace = '0;

        // 1: reset and POR length
        repeat (3) tick();
        check_eq("rst_led", 32'(led), 32'h0000_00FF);
        check_eq("rst_soc", 32'(soc_rst), 32'd1);
        rst = 1'b0;
        highs = 0;
        for (int k = 0; k < 20; k++) begin
            if (soc_rst) highs++;
            tick();
        end
        check_eq("por_len", 32'(highs), 32'd16);

        // 2: glitch rejected, real press steps page, second press wraps
        btn_raw[1] = 1'b1;
        repeat (3) tick();
        btn_raw[1] = 1'b0;
        presses = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (btn_level[1] || btn_press[1]) presses++;
        end
        check_eq("glitch", 32'(presses), 32'd0);
        btn_raw[1] = 1'b1;
        rise_at = 0; presses = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (btn_level[1] && rise_at == 0) rise_at = k;
            if (btn_press[1]) presses++;
        end
        check_eq("db_latency", 32'(rise_at), 32'd6);
        check_eq("press_once", 32'(presses), 32'd1);
        check_eq("page_step", 32'(page), 32'd1);
        btn_raw[1] = 1'b0;
        repeat (8) tick();
        press_button(1);
        check_eq("page_wrap", 32'(page), 32'd0);

        // 3: page views of a live trace
        trace = 12'hA5C;
        tick();
        check_eq("led_pg0", 32'(led), 32'h0000_00A3);
        press_button(1);
        tick();
        check_eq("led_pg1", 32'(led), 32'h0000_00F5);
        press_button(1);

        // 4: freeze holds the snapshot, unfreeze returns to live trace
        trace = 12'h123;
        press_button(2);
        trace = 12'hFFF;
        repeat (2) tick();
        check_eq("frz_on", 32'(frozen), 32'd1);
        check_eq("frz_led", 32'(led), 32'h0000_00DC);
        press_button(2);
        tick();
        check_eq("frz_off", 32'(frozen), 32'd0);
        check_eq("live_led", 32'(led), 32'h0000_0000);

        // 5: long press gives one soft reset per hold
        for (int rep = 0; rep < 2; rep++) begin
            highs = 0; rises = 0; prev = soc_rst;
            btn_raw[0] = 1'b1;
            for (int k = 0; k < 70; k++) begin
                if (k == 60) btn_raw[0] = 1'b0;
                if (soc_rst) highs++;
                if (soc_rst && !prev) rises++;
                prev = soc_rst;
                tick();
            end
            check_eq("soft_rises", 32'(rises), 32'd1);
            check_eq("soft_len", 32'(highs), 32'd16);
        end

        // 6: rst during a debounce with page 1
        press_button(1);
        check_eq("pre_rst_pg", 32'(page), 32'd1);
        btn_raw[1] = 1'b1;
        repeat (3) tick();
        rst = 1'b1; btn_raw[1] = 1'b0;
        tick();
        rst = 1'b0;
        check_eq("rst_page", 32'(page), 32'd0);
        highs = 0; presses = 0;
        for (int k = 0; k < 20; k++) begin
            if (soc_rst) highs++;
            if (btn_press != '0) presses++;
            tick();
        end
        check_eq("rst_por_len", 32'(highs), 32'd16);
        check_eq("rst_no_press", 32'(presses), 32'd0);

        // Random activity against the model
        for (int k = 0; k < 3000; k++) begin
            trace = 12'($urandom);
            if ($urandom_range(0, 39) == 0) btn_raw[0] = ~btn_raw[0];
            for (int b = 1; b < NB; b++) begin
                if ($urandom_range(0, 7) == 0) btn_raw[b] = ~btn_raw[b];
            end
            rst = ($urandom_range(0, 399) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
